// File: rtl/apb_master.sv
// APB3 requester: valid/ready command in, IDLE->SETUP->ACCESS transfer out, one-cycle response strobe.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
`endif

  // cmd_ready is a register so it stays low throughout reset and rises on the first edge after.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PWRITE    <= cmd_write;
            PSEL      <= 1'b1;
            PENABLE   <= 1'b0;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        ACCESS: begin
          // PREADY wins over a timeout landing on the same edge.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= PSLVERR;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            cmd_ready <= 1'b1;
            to_cnt    <= to_cnt + 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: bench-driven responder, hand-computed expectations.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int n_assert = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

    // reset state
    @(negedge PCLK);
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_paddr", PADDR, 32'h0);
    chk32("rst_pwdata", PWDATA, 32'h0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk1("rdy_after_rst", cmd_ready, 1'b1);

    // zero-wait write; PREADY already high during SETUP must be ignored
    issue(1'b1, 32'h5, 32'hDEADBEEF);
    PREADY = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk1("wr_setup_psel", PSEL, 1'b1);
    chk1("wr_setup_penable", PENABLE, 1'b0);
    chk1("wr_setup_ready", cmd_ready, 1'b0);
    chk1("wr_setup_pwrite", PWRITE, 1'b1);
    chk32("wr_setup_paddr", PADDR, 32'h5);
    chk32("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    chk1("wr_access_psel", PSEL, 1'b1);
    chk1("wr_access_penable", PENABLE, 1'b1);
    chk1("wr_access_rsp", rsp_valid, 1'b0);
    chk32("wr_access_paddr", PADDR, 32'h5);
    chk32("wr_access_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    chk1("wr_rsp_valid", rsp_valid, 1'b1);
    chk1("wr_rsp_err", rsp_err, 1'b0);
    chk32("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk1("wr_done_psel", PSEL, 1'b0);
    chk1("wr_done_penable", PENABLE, 1'b0);
    chk1("wr_done_ready", cmd_ready, 1'b1);
    chk32("wr_done_paddr_hold", PADDR, 32'h5);
    @(negedge PCLK);
    chk1("wr_rsp_one_cycle", rsp_valid, 1'b0);

    // read with 3 wait states; junk PRDATA during SETUP must not be captured
    issue(1'b0, 32'h5, 32'h0);
    PREADY = 1'b0; PRDATA = 32'h11111111;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk1("rd_setup_penable", PENABLE, 1'b0);
    chk1("rd_setup_pwrite", PWRITE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk1("rd_wait_penable", PENABLE, 1'b1);
      chk1("rd_wait_rsp", rsp_valid, 1'b0);
    end
    PREADY = 1'b1; PRDATA = 32'hDEADBEEF;
    @(negedge PCLK);
    PREADY = 1'b0; PRDATA = 32'h0;
    chk1("rd_rsp_valid", rsp_valid, 1'b1);
    chk32("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk1("rd_rsp_err", rsp_err, 1'b0);
    @(negedge PCLK);
    chk1("rd_rsp_one_cycle", rsp_valid, 1'b0);
    chk32("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // slave error
    issue(1'b0, 32'h40, 32'h0);
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE0000;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk32("err_access_paddr", PADDR, 32'h40);
    @(negedge PCLK);
    PSLVERR = 1'b0;
    chk1("err_rsp_valid", rsp_valid, 1'b1);
    chk1("err_rsp_err", rsp_err, 1'b1);
    chk32("err_rsp_rdata", rsp_rdata, 32'hCAFE0000);
    @(negedge PCLK);
    chk1("err_rsp_one_cycle", rsp_valid, 1'b0);
    chk1("err_bus_idle", PSEL, 1'b0);
    chk1("err_hold", rsp_err, 1'b1);

    // back-to-back writes with cmd_valid held high
    PRDATA = 32'h0;
    for (int k = 1; k <= 3; k++) begin
      issue(1'b1, 32'(k), 32'(k * 256));
      @(negedge PCLK);
      chk32("b2b_setup_paddr", PADDR, 32'(k));
      chk32("b2b_setup_pwdata", PWDATA, 32'(k * 256));
      chk1("b2b_setup_ready", cmd_ready, 1'b0);
      chk1("b2b_setup_penable", PENABLE, 1'b0);
      @(negedge PCLK);
      chk1("b2b_access_ready", cmd_ready, 1'b0);
      chk1("b2b_access_penable", PENABLE, 1'b1);
      chk1("b2b_access_rsp", rsp_valid, 1'b0);
      @(negedge PCLK);
      chk1("b2b_rsp_valid", rsp_valid, 1'b1);
      chk1("b2b_idle_psel", PSEL, 1'b0);
      chk32("b2b_rsp_paddr", PADDR, 32'(k));
    end
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk1("b2b_no_extra", PSEL, 1'b0);
    chk1("b2b_no_extra_rsp", rsp_valid, 1'b0);

    // reset during ACCESS
    issue(1'b1, 32'h77, 32'h55);
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk1("mid_access_penable", PENABLE, 1'b1);
    #2 PRESET = 1'b0;
    #1;
    chk1("mid_rst_psel_async", PSEL, 1'b0);
    chk1("mid_rst_penable_async", PENABLE, 1'b0);
    @(negedge PCLK);
    chk1("mid_rst_no_rsp", rsp_valid, 1'b0);
    chk1("mid_rst_ready", cmd_ready, 1'b0);
    PRESET = 1'b1; PREADY = 1'b1;
    @(negedge PCLK);
    chk1("post_rst_ready", cmd_ready, 1'b1);
    chk1("post_rst_no_rsp", rsp_valid, 1'b0);
    issue(1'b1, 32'h9, 32'h12345678);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    chk32("post_rst_paddr", PADDR, 32'h9);
    @(negedge PCLK);
    @(negedge PCLK);
    chk1("post_rst_rsp_valid", rsp_valid, 1'b1);
    chk1("post_rst_rsp_err", rsp_err, 1'b0);
    chk32("post_rst_pwdata", PWDATA, 32'h12345678);

`ifdef APB_TIMEOUT_EN
    // PREADY never comes: abort after 16 ACCESS cycles
    issue(1'b0, 32'h3, 32'h0);
    PREADY = 1'b0; PRDATA = 32'hBAD0BAD0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      chk1("to_wait_penable", PENABLE, 1'b1);
      chk1("to_wait_rsp", rsp_valid, 1'b0);
    end
    @(negedge PCLK);
    chk1("to_rsp_valid", rsp_valid, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk32("to_rsp_rdata", rsp_rdata, 32'h0);
    chk1("to_psel", PSEL, 1'b0);
    chk1("to_ready", cmd_ready, 1'b1);
    // PREADY arrives on the limit edge: normal completion
    issue(1'b0, 32'h3, 32'h0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge PCLK);
      chk1("to2_wait_rsp", rsp_valid, 1'b0);
    end
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0000ABCD;
    @(negedge PCLK);
    PREADY = 1'b0;
    chk1("to2_rsp_valid", rsp_valid, 1'b1);
    chk1("to2_rsp_err", rsp_err, 1'b0);
    chk32("to2_rsp_rdata", rsp_rdata, 32'h0000ABCD);
`else
    // without the timeout ACCESS waits indefinitely
    issue(1'b0, 32'h20, 32'h0);
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      chk1("long_wait_penable", PENABLE, 1'b1);
      chk1("long_wait_rsp", rsp_valid, 1'b0);
    end
    PREADY = 1'b1; PRDATA = 32'h00005A5A;
    @(negedge PCLK);
    PREADY = 1'b0;
    chk1("long_rsp_valid", rsp_valid, 1'b1);
    chk1("long_rsp_err", rsp_err, 1'b0);
    chk32("long_rsp_rdata", rsp_rdata, 32'h00005A5A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that turns a simple valid/ready command interface into APB3 transfers (IDLE -> SETUP -> ACCESS) driven onto PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Returns read data and error status on a one-cycle response strobe.
- Sits between an internal controller (CPU bridge, DMA, test sequencer) and the APB slaves on the team's peripheral bus.
- Handles one outstanding transfer at a time; wait states are inserted by the responder through PREADY.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and PADDR
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
PCLK  input  1  bus clock; all logic on rising edge
PRESET  input  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse: transfer finished
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  PSLVERR or timeout, qualified by rsp_valid
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  responder ready
PSLVERR  input  1  responder error
PRDATA  input  DATA_WIDTH  responder read data

Behaviour:
- Reset (PRESET=0, asynchronous): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0; cmd_ready=0 while in reset, and 1 from the first clock edge after release.
- All APB outputs and rsp_* are registered.
- cmd_ready = 1 only in IDLE. A command is accepted on an edge with cmd_valid & cmd_ready. Address, data and direction are captured into PADDR/PWDATA/PWRITE on that edge.
- IDLE: on accept -> SETUP, with PSEL=1 and PENABLE=0 from that edge.
- SETUP: exactly one cycle; PREADY is ignored. Next edge -> ACCESS with PENABLE=1.
- ACCESS: PSEL=1, PENABLE=1; PADDR, PWDATA and PWRITE are held stable. On an edge with PREADY=1:
  - Complete: PSEL=0, PENABLE=0, return to IDLE.
  - rsp_valid=1 for exactly one cycle.
  - rsp_err = PSLVERR.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - With PREADY=0, stay in ACCESS indefinitely (no timeout unless the optional feature is compiled in).
- Minimum latency: accept at edge T, SETUP in cycle T..T+1, ACCESS from T+1, rsp_valid visible after edge T+2 when PREADY=1 on the first ACCESS edge. Throughput is one transfer per 3 cycles minimum, because IDLE is revisited between transfers.
- PSLVERR and PRDATA are sampled only on the ACCESS edge with PREADY=1, never in SETUP.
- After a completed transfer PADDR, PWDATA and PWRITE keep their last values. rsp_rdata and rsp_err hold until the next completion.
- cmd_valid while busy is ignored (cmd_ready=0); the command is not lost, since the requester must hold it.
- Reset mid-transfer: bus returns immediately to PSEL=PENABLE=0 and no rsp_valid is produced.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on SETUP->ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, on that edge:
  - Drop PSEL/PENABLE and return to IDLE.
  - rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 on the same edge as the limit takes priority; the transfer completes normally.
- Undefined: no counter logic; ACCESS waits indefinitely.

Test Plan:
- Zero-wait write (bench responder): write addr 0x5, data 0xDEADBEEF -> PSEL high 2 cycles, PENABLE 1 cycle, PADDR=0x5, PWDATA=0xDEADBEEF stable throughout; rsp_valid pulse 2 edges after accept; rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: read addr 0x5, responder returns PRDATA=0xDEADBEEF after 3 PREADY=0 cycles -> ACCESS lasts 4 cycles; rsp_rdata=0xDEADBEEF; PRDATA driven during SETUP is not captured.
- Error: read addr 0x40, responder PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_valid one cycle, bus idle next cycle.
- Back-to-back: cmd_valid held high for 3 writes (addr 1, 2, 3) -> cmd_ready low during SETUP/ACCESS; PSEL returns low for 1 IDLE cycle between transfers; 3 rsp_valid pulses in order.
- Reset mid-ACCESS: assert PRESET=0 during ACCESS with PREADY=0 -> PSEL/PENABLE fall asynchronously, no rsp_valid; after release, a new write completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16: PREADY held 0 -> abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0. Repeat with PREADY=1 on cycle 16 -> normal completion, rsp_err=PSLVERR.
